acx_axi_req_splitter: RTL and testbench

Downstream stage of the AXI request FIFO. It pops queued INCR read/write address requests ({id, len, addr}) and reissues each one on an AXI AR/AW-style valid/ready channel toward the NAP. It splits each request into sub-bursts so that no sub-burst crosses a 4 KB boundary or exceeds MAX_BEATS beats.

---
 rtl/acx_axi_req_splitter.sv | 133 +++++++++++++
 tb/tb_acx_axi_req_splitter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acx_axi_req_splitter.sv
// acx_axi_req_splitter: pops {id, len, addr} INCR requests from the request
// FIFO and reissues them as AXI AR/AW sub-bursts that never cross a 4 KB
// boundary and never exceed MAX_BEATS beats.
module acx_axi_req_splitter #(
    parameter int ADDR_W    = 42,
    parameter int ID_W      = 8,
    parameter int LEN_W     = 8,
    parameter int BEAT_LOG2 = 5,
    parameter int MAX_BEATS = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [ID_W+LEN_W+ADDR_W-1:0] i_req_data,
    input  logic                         i_req_valid,
    output logic                         o_req_pop,
    output logic                         o_axi_valid,
    input  logic                         i_axi_ready,
    output logic [ADDR_W-1:0]            o_axi_addr,
    output logic [LEN_W-1:0]             o_axi_len,
    output logic [ID_W-1:0]              o_axi_id,
    output logic                         o_axi_last,
    output logic                         o_busy
);

    // rem holds 1..2^LEN_W, so it needs one bit more than len
    localparam int RW = LEN_W + 1;
    // chunk math must hold both rem and the 4 KB beat count (up to 4096)
    localparam int CW = (RW > 13) ? RW : 13;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << BEAT_LOG2) - ADDR_W'(1));

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [ADDR_W-1:0] req_addr, calc_addr;
    logic [LEN_W-1:0]  req_len;
    logic [ID_W-1:0]   req_id;
    logic [RW-1:0]     cur_chunk, calc_rem;
    logic [CW-1:0]     b4k, chunk;
    logic              hs, load, calc_last;

    assign req_addr = i_req_data[ADDR_W-1:0];
    assign req_len  = i_req_data[ADDR_W +: LEN_W];
    assign req_id   = i_req_data[ADDR_W+LEN_W +: ID_W];

    assign hs        = valid_q & i_axi_ready;
    // A new parent request is taken from IDLE or on the final handshake
    assign load      = i_req_valid & ((state_q == IDLE) | (hs & last_q));
    assign cur_chunk = RW'(len_q) + RW'(1);

    // One chunk calculator shared by load and advance: the next sub-burst
    // starts either at the fresh request or just past the current one.
    always_comb begin
        if (load) begin
            calc_addr = req_addr & ALIGN_MASK;
            calc_rem  = RW'(req_len) + RW'(1);
        end else begin
            calc_addr = cur_addr_q + (ADDR_W'(cur_chunk) << BEAT_LOG2);
            calc_rem  = rem_q - cur_chunk;
        end
        b4k   = (CW'(4096) - CW'(calc_addr[11:0])) >> BEAT_LOG2;
        chunk = CW'(calc_rem);
        if (chunk > CW'(MAX_BEATS)) chunk = CW'(MAX_BEATS);
        if (chunk > b4k)            chunk = b4k;
        calc_last = (chunk == CW'(calc_rem));
    end

    // Next-state and output-register logic; outputs hold while stalled
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        last_d     = last_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        id_d       = id_q;
        if (load) begin
            state_d    = ISSUE;
            valid_d    = 1'b1;
            cur_addr_d = calc_addr;
            rem_d      = calc_rem;
            len_d      = LEN_W'(chunk - CW'(1));
            id_d       = req_id;
            last_d     = calc_last;
        end else if (state_q == ISSUE && hs) begin
            if (!last_q) begin
                cur_addr_d = calc_addr;
                rem_d      = calc_rem;
                len_d      = LEN_W'(chunk - CW'(1));
                last_d     = calc_last;
            end else begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    // State and output registers; reset drops any in-flight request
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            cur_addr_q <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            id_q       <= id_d;
        end
    end

    assign o_req_pop   = load;
    assign o_axi_valid = valid_q;
    assign o_axi_addr  = cur_addr_q;
    assign o_axi_len   = len_q;
    assign o_axi_id    = id_q;
    assign o_axi_last  = last_q;
    assign o_busy      = (state_q == ISSUE);

endmodule

// File: tb/tb_acx_axi_req_splitter.sv
// Directed bench for acx_axi_req_splitter: a small FIFO model feeds the DUT,
// a negedge monitor logs handshakes and pops, scenarios compare the logs
// against hand-computed sub-burst lists.
module tb_acx_axi_req_splitter;

    localparam int ADDR_W = 42, ID_W = 8, LEN_W = 8;
    localparam int DW = ID_W + LEN_W + ADDR_W;

    logic              i_clk = 1'b0;
    logic              i_rstn = 1'b1;
    logic [DW-1:0]     i_req_data = '0;
    logic              i_req_valid = 1'b0;
    logic              o_req_pop;
    logic              o_axi_valid;
    logic              i_axi_ready = 1'b0;
    logic [ADDR_W-1:0] o_axi_addr;
    logic [LEN_W-1:0]  o_axi_len;
    logic [ID_W-1:0]   o_axi_id;
    logic              o_axi_last;
    logic              o_busy;

    acx_axi_req_splitter dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req_data(i_req_data), .i_req_valid(i_req_valid), .o_req_pop(o_req_pop),
        .o_axi_valid(o_axi_valid), .i_axi_ready(i_axi_ready),
        .o_axi_addr(o_axi_addr), .o_axi_len(o_axi_len), .o_axi_id(o_axi_id),
        .o_axi_last(o_axi_last), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int     cyc;
        longint addr;
        int     len;
        int     id;
        bit     last;
    } hs_t;

    hs_t           hs_q[$];
    int            pop_q[$];
    logic [DW-1:0] fifo[$];
    int            cyc = 0;
    int            npop = 0;
    int            napplied = 0;
    int            n_chk = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Log handshakes and pops mid-cycle
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (o_axi_valid && i_axi_ready)
                hs_q.push_back('{cyc, longint'(o_axi_addr), int'(o_axi_len),
                                 int'(o_axi_id), o_axi_last});
            if (o_req_pop) begin
                pop_q.push_back(cyc);
                npop++;
            end
        end
    end

    function automatic logic [DW-1:0] mk(input int id, input int len, input longint a);
        return {ID_W'(id), LEN_W'(len), ADDR_W'(a)};
    endfunction

    task automatic drive();
        i_req_valid = (fifo.size() != 0);
        i_req_data  = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        while (napplied < npop) begin
            if (fifo.size() != 0) void'(fifo.pop_front());
            napplied++;
        end
        drive();
    endtask

    task automatic push(input int id, input int len, input longint a);
        fifo.push_back(mk(id, len, a));
        drive();
    endtask

    task automatic clear_logs();
        hs_q.delete();
        pop_q.delete();
    endtask

    task automatic run_idle(input string tag, input int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((o_busy || fifo.size() != 0) && n < maxc);
        chk({tag, "_done_in_time"}, longint'(n < maxc), 1);
    endtask

    task automatic exp_hs(input string tag, input int i, input longint a,
                          input int len, input int id, input bit last);
        if (i < hs_q.size()) begin
            chk($sformatf("%s[%0d].addr", tag, i), hs_q[i].addr, a);
            chk($sformatf("%s[%0d].len", tag, i), hs_q[i].len, len);
            chk($sformatf("%s[%0d].id", tag, i), hs_q[i].id, id);
            chk($sformatf("%s[%0d].last", tag, i), longint'(hs_q[i].last), longint'(last));
        end else begin
            chk($sformatf("%s[%0d].present", tag, i), 0, 1);
        end
    endtask

    // Four 16-beat sub-bursts for len=63 at 0x0
    task automatic exp_split64(input string tag, input int id);
        chk({tag, "_nhs"}, hs_q.size(), 4);
        for (int i = 0; i < 4; i++)
            exp_hs(tag, i, longint'(i) * 'h200, 15, id, i == 3);
        chk({tag, "_npop"}, pop_q.size(), 1);
    endtask

    initial begin
        // Reset state
        #1 i_rstn = 1'b0;
        tick();
        tick();
        chk("rst_valid", o_axi_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pop", o_req_pop, 0);
        chk("rst_last", o_axi_last, 0);
        chk("rst_addr", o_axi_addr, 0);
        chk("rst_len", o_axi_len, 0);
        chk("rst_id", o_axi_id, 0);
        i_rstn = 1'b1;
        tick();
        i_axi_ready = 1'b1;

        // 1: single request, no split
        clear_logs();
        push(3, 7, 'h1000);
        run_idle("s1", 20);
        chk("s1_nhs", hs_q.size(), 1);
        exp_hs("s1", 0, 'h1000, 7, 3, 1);
        chk("s1_npop", pop_q.size(), 1);
        if (hs_q.size() == 1 && pop_q.size() == 1)
            chk("s1_latency", hs_q[0].cyc - pop_q[0], 1);
        chk("s1_idle_valid", o_axi_valid, 0);

        // 2: MAX_BEATS split, consecutive cycles
        clear_logs();
        push(4, 63, 'h0);
        run_idle("s2", 30);
        exp_split64("s2", 4);
        if (hs_q.size() == 4)
            chk("s2_back_to_back", hs_q[3].cyc - hs_q[0].cyc, 3);

        // 3a: 4 KB split, 2 beats before the boundary
        clear_logs();
        push(6, 3, 'hFC0);
        run_idle("s3a", 20);
        chk("s3a_nhs", hs_q.size(), 2);
        exp_hs("s3a", 0, 'hFC0, 1, 6, 0);
        exp_hs("s3a", 1, 'h1000, 1, 6, 1);

        // 3b: 256 beats from 0xF00: 8 beats, fifteen x16, then 8 beats
        clear_logs();
        push(7, 255, 'hF00);
        run_idle("s3b", 60);
        chk("s3b_nhs", hs_q.size(), 17);
        exp_hs("s3b", 0, 'hF00, 7, 7, 0);
        for (int i = 1; i <= 15; i++)
            exp_hs("s3b", i, 'h1000 + longint'(i - 1) * 'h200, 15, 7, 0);
        exp_hs("s3b", 16, 'h2E00, 7, 7, 1);
        chk("s3b_npop", pop_q.size(), 1);

        // 4: backpressure on the 2nd sub-burst
        clear_logs();
        push(8, 63, 'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_axi_valid && o_axi_addr == 'h200) break;
        end
        chk("s4_reached_2nd", o_axi_addr, 'h200);
        i_axi_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s4_hold_valid", o_axi_valid, 1);
            chk("s4_hold_addr", o_axi_addr, 'h200);
            chk("s4_hold_len", o_axi_len, 15);
            chk("s4_no_pop", npop - napplied + pop_q.size(), 1);
        end
        i_axi_ready = 1'b1;
        run_idle("s4", 30);
        exp_split64("s4", 8);
        if (hs_q.size() == 4)
            chk("s4_stall_gap", hs_q[1].cyc - hs_q[0].cyc, 6);

        // 5: back-to-back requests
        clear_logs();
        push(1, 15, 'h0);
        push(2, 0, 'h4000);
        run_idle("s5", 20);
        chk("s5_nhs", hs_q.size(), 2);
        exp_hs("s5", 0, 'h0, 15, 1, 1);
        exp_hs("s5", 1, 'h4000, 0, 2, 1);
        chk("s5_npop", pop_q.size(), 2);
        if (hs_q.size() == 2 && pop_q.size() == 2) begin
            chk("s5_pop2_at_hs1", pop_q[1], hs_q[0].cyc);
            chk("s5_no_bubble", hs_q[1].cyc - hs_q[0].cyc, 1);
        end

        // 6: asynchronous reset during the 2nd sub-burst
        clear_logs();
        push(9, 63, 'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_axi_valid && o_axi_addr == 'h200) break;
        end
        chk("s6_reached_2nd", o_axi_addr, 'h200);
        #2 i_rstn = 1'b0;
        #1;
        chk("s6_rst_valid", o_axi_valid, 0);
        chk("s6_rst_busy", o_busy, 0);
        chk("s6_rst_pop", o_req_pop, 0);
        chk("s6_rst_addr", o_axi_addr, 0);
        fifo.delete();
        napplied = npop;
        drive();
        tick();
        tick();
        i_rstn = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s6_stay_idle", o_busy, 0);
        end
        chk("s6_no_hs_after_rst", hs_q.size(), 0);
        // Misaligned address: low beat bits must be dropped
        push(5, 1, 'h201F);
        run_idle("s6", 20);
        chk("s6_nhs", hs_q.size(), 1);
        exp_hs("s6", 0, 'h2000, 1, 5, 1);
        chk("s6_npop", pop_q.size(), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Hard stop in case a scenario loop never returns
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
